// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the NPC instruction fetch stage.
// Covers the reset PC default, the fetch FSM encoding and the instruction queue entry layout.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [1:0]  RRESP_OKAY       = 2'b00;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_RESP = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// Small synchronous instruction queue of {fault, pc, inst} entries with flush and occupancy count.
// The head entry is presented combinationally; a push and a pop on a full queue may share a cycle.
module ifu_inst_buf
    import ifu_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  ifu_entry_t       push_data,
    input  logic             pop,
    output ifu_entry_t       head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    ifu_entry_t       mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// NPC instruction fetch: PC, single-outstanding AXI4-Lite read, and a queue feeding decode.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    output logic [31:0] mem_araddr,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    ifu_state_e       state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      req_addr_reg, req_addr_next;
    logic             drop_reg, drop_next;
    logic             halt_reg, halt_next;
    logic             push;
    ifu_entry_t       push_data;
    logic             pop;
    ifu_entry_t       buf_head;
    logic [CNT_W-1:0] buf_count;
    logic             buf_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IFU_IDLE;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            drop_reg     <= 1'b0;
            halt_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_addr_reg <= req_addr_next;
            drop_reg     <= drop_next;
            halt_reg     <= halt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        req_addr_next  = req_addr_reg;
        drop_next      = drop_reg;
        halt_next      = halt_reg;
        mem_arvalid    = 1'b0;
        mem_rready     = 1'b0;
        push           = 1'b0;
        push_data      = '0;

        case (state_reg)
            IFU_IDLE: begin
                // In IDLE nothing is outstanding, so room in the queue is the only gate.
                if (!redirect_valid && !halt_reg && (buf_count < CNT_W'(BUF_DEPTH))) begin
                    if (is_misaligned(pc_reg)) begin
                        push            = 1'b1;
                        push_data.fault = 1'b1;
                        push_data.pc    = pc_reg;
                        halt_next       = 1'b1;
                    end else begin
                        state_next    = IFU_REQ;
                        req_addr_next = pc_reg;
                    end
                end
            end
            IFU_REQ: begin
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    state_next = IFU_RESP;
                    // A stale request (redirected while waiting) must not advance the new PC.
                    if (!drop_reg) begin
                        pc_next = pc_reg + 32'd4;
                    end
                end
                if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            IFU_RESP: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    state_next = IFU_IDLE;
                    drop_next  = 1'b0;
                    if (!drop_reg && !redirect_valid) begin
                        push            = 1'b1;
                        push_data.fault = (mem_rresp != RRESP_OKAY);
                        push_data.pc    = req_addr_reg;
                        push_data.inst  = (mem_rresp != RRESP_OKAY) ? 32'h0 : mem_rdata;
                        if (mem_rresp != RRESP_OKAY) begin
                            halt_next = 1'b1;
                        end
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = IFU_IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_next   = redirect_pc;
            halt_next = 1'b0;
        end
    end

    // The flush wins over a same-cycle pop, so decode never consumes a squashed entry.
    assign pop = inst_valid && inst_ready && !redirect_valid;

    ifu_inst_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign mem_araddr = req_addr_reg;
    assign inst_valid = !buf_empty;
    assign inst       = inst_valid ? buf_head.inst : 32'h0;
    assign inst_pc    = inst_valid ? buf_head.pc   : 32'h0;
    assign inst_fault = inst_valid ? buf_head.fault : 1'b0;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_reg <= 32'h0;
            perf_stall_cnt_reg <= 32'h0;
        end else begin
            if (push && (state_reg == IFU_RESP)) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (inst_valid && !inst_ready) begin
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small AXI4-Lite read slave plus logs of accepted
// addresses and decoded-side pops, checked against hand-computed values.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_arvalid    (mem_arvalid),
        .mem_arready    (mem_arready),
        .mem_araddr     (mem_araddr),
        .mem_rvalid     (mem_rvalid),
        .mem_rready     (mem_rready),
        .mem_rdata      (mem_rdata),
        .mem_rresp      (mem_rresp),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } pop_t;

    pop_t        pop_log [$];
    logic [31:0] ar_log [$];
    int          n_cmp;
    int          n_err;
    int          arvalid_cycles;
    bit          pend;
    logic [31:0] pend_addr;
    int          dly;
    int          r_delay;
    logic [31:0] fault_addr;

    // Memory contents seen by the fetch unit.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ar_at(input int i);
        return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_pc(input int i);
        return (i < pop_log.size()) ? pop_log[i].pc : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_inst(input int i);
        return (i < pop_log.size()) ? pop_log[i].inst : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] pop_fault(input int i);
        return (i < pop_log.size()) ? 32'(pop_log[i].fault) : 32'hDEAD_DEAD;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One clock: snapshot the handshakes the coming edge performs, then update the slave.
    task automatic tick();
        bit          ar_hs;
        bit          r_hs;
        bit          pop_hs;
        logic [31:0] ar_a;
        pop_t        p;
        ar_hs   = mem_arvalid && mem_arready;
        ar_a    = mem_araddr;
        r_hs    = mem_rvalid && mem_rready;
        pop_hs  = inst_valid && inst_ready && !redirect_valid;
        p.inst  = inst;
        p.pc    = inst_pc;
        p.fault = inst_fault;
        if (mem_arvalid) arvalid_cycles++;
        @(negedge clk);
        if (r_hs) pend = 1'b0;
        if (ar_hs) begin
            pend      = 1'b1;
            pend_addr = ar_a;
            dly       = r_delay;
            ar_log.push_back(ar_a);
            $display("ar  accept addr=%08h", ar_a);
        end
        if (pop_hs) begin
            pop_log.push_back(p);
            $display("pop pc=%08h inst=%08h fault=%0d", p.pc, p.inst, p.fault);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_rresp  = 2'b00;
        if (pend) begin
            if (dly > 0) begin
                dly--;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
                mem_rresp  = (pend_addr == fault_addr) ? 2'b10 : 2'b00;
            end
        end
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (pop_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(pop_log.size()), 32'(n));
    endtask

    task automatic wait_ars(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (ar_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(ar_log.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        mem_arready    = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        mem_rresp      = 2'b00;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pend           = 1'b0;
        dly            = 0;
        r_delay        = 0;
        fault_addr     = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ar_log.delete();
        pop_log.delete();
        arvalid_cycles = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        arvalid_cycles = 0;
        rst = 1'b1;
        mem_arready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        mem_rresp = 2'b00;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_arvalid", 32'(mem_arvalid), 32'h0);
        check_eq("rst_rready",  32'(mem_rready),  32'h0);
        check_eq("rst_ivalid",  32'(inst_valid),  32'h0);
        check_eq("rst_inst",    inst,             32'h0);
        check_eq("rst_inst_pc", inst_pc,          32'h0);
        check_eq("rst_fault",   32'(inst_fault),  32'h0);
        check_eq("rst_araddr",  mem_araddr,       32'h8000_0000);

        // 1: free-running memory and decode
        do_reset();
        mem_arready = 1'b1;
        inst_ready  = 1'b1;
        wait_pops("t1_pops", 4, 60);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_araddr", ar_at(i),     32'h8000_0000 + 32'(4 * i));
            check_eq("t1_pc",     pop_pc(i),    32'h8000_0000 + 32'(4 * i));
            check_eq("t1_inst",   pop_inst(i),  mem_word(32'h8000_0000 + 32'(4 * i)));
            check_eq("t1_fault",  pop_fault(i), 32'h0);
        end

        // 2: decode stalled, queue fills, then drains in order
        do_reset();
        mem_arready = 1'b1;
        inst_ready  = 1'b0;
        repeat (30) tick();
        check_eq("t2_ar_count", 32'(ar_log.size()), 32'd2);
        check_eq("t2_arvalid",  32'(mem_arvalid),   32'h0);
        check_eq("t2_ivalid",   32'(inst_valid),    32'h1);
        check_eq("t2_head_pc",  inst_pc,            32'h8000_0000);
        check_eq("t2_head_ins", inst,               mem_word(32'h8000_0000));
        inst_ready = 1'b1;
        wait_pops("t2_pops", 3, 40);
        check_eq("t2_pc0", pop_pc(0), 32'h8000_0000);
        check_eq("t2_pc1", pop_pc(1), 32'h8000_0004);
        check_eq("t2_pc2", pop_pc(2), 32'h8000_0008);
        check_eq("t2_ar2", ar_at(2),  32'h8000_0008);

        // 3: redirect while waiting for a delayed response
        do_reset();
        mem_arready = 1'b1;
        inst_ready  = 1'b1;
        r_delay     = 3;
        wait_ars("t3_first_ar", 1, 10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        wait_pops("t3_pops", 2, 60);
        check_eq("t3_pc0",   pop_pc(0),   32'h8000_0100);
        check_eq("t3_inst0", pop_inst(0), mem_word(32'h8000_0100));
        check_eq("t3_pc1",   pop_pc(1),   32'h8000_0104);
        check_eq("t3_ar1",   ar_at(1),    32'h8000_0100);

        // 4: access fault halts fetch until redirect
        do_reset();
        mem_arready = 1'b1;
        inst_ready  = 1'b1;
        fault_addr  = 32'h8000_0010;
        wait_pops("t4_pops", 5, 100);
        check_eq("t4_ok_fault", pop_fault(3), 32'h0);
        check_eq("t4_fault",    pop_fault(4), 32'h1);
        check_eq("t4_fault_pc", pop_pc(4),    32'h8000_0010);
        check_eq("t4_fault_in", pop_inst(4),  32'h0);
        repeat (20) tick();
        check_eq("t4_halted", 32'(ar_log.size()), 32'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        wait_ars("t4_resume", 6, 20);
        check_eq("t4_ar5", ar_at(5), 32'h8000_0200);

        // 5: misaligned redirect target faults without touching memory
        do_reset();
        mem_arready    = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        check_eq("t5_no_arvalid", 32'(arvalid_cycles), 32'd0);
        check_eq("t5_ivalid",     32'(inst_valid),     32'h1);
        check_eq("t5_fault",      32'(inst_fault),     32'h1);
        check_eq("t5_pc",         inst_pc,             32'h8000_0102);
        check_eq("t5_inst",       inst,                32'h0);

        // 6: slow arready with a redirect while the request is pending
        do_reset();
        mem_arready = 1'b0;
        inst_ready  = 1'b1;
        for (int k = 0; k < 10 && !mem_arvalid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_arvalid_hold", 32'(mem_arvalid), 32'h1);
            check_eq("t6_araddr_hold",  mem_araddr,       32'h8000_0000);
            redirect_valid = (i == 2);
            redirect_pc    = 32'h8000_0300;
            tick();
        end
        redirect_valid = 1'b0;
        mem_arready    = 1'b1;
        wait_pops("t6_pops", 1, 30);
        check_eq("t6_ar0",   ar_at(0),    32'h8000_0000);
        check_eq("t6_ar1",   ar_at(1),    32'h8000_0300);
        check_eq("t6_pc0",   pop_pc(0),   32'h8000_0300);
        check_eq("t6_inst0", pop_inst(0), mem_word(32'h8000_0300));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
